mod_mul_serial: RTL and testbench



---
 rtl/mod_mul_serial_if.sv | 35 +++
 rtl/mod_mul_serial.sv | 118 +++++++++++
 tb/tb_mod_mul_serial.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_mul_serial_if.sv
// mod_mul_serial_if
//   Groups the start/busy/done handshake and the operand/result buses of the
//   serial modular multiplier so they travel as one port.
//
//   start : request from the master, sampled by the multiplier only when idle
//   a, b  : multiplicand and multiplier, both expected below p
//   p     : odd modulus with its top bit set
//   busy  : high while an operation is in progress
//   done  : one-cycle pulse marking r as valid
//   r     : result a*b mod p, held until the next accepted start
interface mod_mul_serial_if #(
  parameter int WIDTH = 256
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] p;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] r;

  // The requester drives operands and start, and watches the status and result
  modport master (
    output start, a, b, p,
    input  busy, done, r
  );

  // The multiplier consumes operands and start, and drives the status and result
  modport slave (
    input  start, a, b, p,
    output busy, done, r
  );

endinterface

// File: rtl/mod_mul_serial.sv
// mod_mul_serial
//   Bit-serial interleaved modular multiplier: r = a*b mod p.
//   One bit of b is consumed per clock, most significant bit first, so a
//   WIDTH-bit product takes WIDTH iterations after the start is accepted.
//   Each iteration doubles the accumulator, reduces it, conditionally adds a,
//   and reduces again. Both reductions are a single compare/subtract because
//   every intermediate value stays below 2p.
//
//   Ports
//     clk : rising-edge clock
//     rst : synchronous active-high reset; aborts an operation without a done
//     bus : mod_mul_serial_if slave modport (start/a/b/p in, busy/done/r out)
//
//   Parameters
//     WIDTH : operand and modulus width
//     CNT_W : bit counter width, 2**CNT_W must be at least WIDTH
module mod_mul_serial #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  mod_mul_serial_if.slave bus
);

  // Two-state controller, kept as plain constants so the encoding is visible
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Intermediate sums are kept two bits wider than the operands so nothing is
  // truncated before the comparison against p.
  localparam int EW = WIDTH + 2;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_res;
  logic             r_busy;
  logic             r_done;

  logic [EW-1:0]    w_pExt;
  logic [EW-1:0]    w_dbl;
  logic [WIDTH-1:0] w_t;
  logic [EW-1:0]    w_addend;
  logic [EW-1:0]    w_sum;
  logic [WIDTH-1:0] w_u;
  logic             w_bit;

  // One iteration of the interleaved algorithm, evaluated every cycle and used
  // only while running. When a reduction is taken the true difference is below
  // p < 2**WIDTH, so subtracting in WIDTH bits yields the exact value.
  always_comb begin
    w_pExt   = {2'b00, r_p};
    w_dbl    = {1'b0, r_acc, 1'b0};
    w_t      = (w_dbl >= w_pExt) ? (w_dbl[WIDTH-1:0] - r_p) : w_dbl[WIDTH-1:0];
    w_bit    = r_b[r_cnt];
    w_addend = w_bit ? {2'b00, r_a} : '0;
    w_sum    = {2'b00, w_t} + w_addend;
    w_u      = (w_sum >= w_pExt) ? (w_sum[WIDTH-1:0] - r_p) : w_sum[WIDTH-1:0];
  end

  // Controller and datapath registers. Reset wins over everything, including
  // an operation in flight. done is cleared on every idle cycle so it can only
  // ever be high for the single cycle after the last iteration; a start seen in
  // that same cycle is accepted, giving back-to-back operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_p     <= bus.p;
            r_acc   <= '0;
            r_cnt   <= CNT_W'(WIDTH - 1);
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_u;
          if (r_cnt == '0) begin
            r_res   <= w_u;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.r    = r_res;

endmodule

// File: tb/tb_mod_mul_serial.sv
// tb_mod_mul_serial
//   Scoreboard bench for mod_mul_serial. The driver issues operations and
//   pushes the expected product (computed with wide multiply and modulo) into
//   a queue; a monitor pops and compares whenever done pulses.
module tb_mod_mul_serial;

  localparam int WIDTH = 256;

  localparam logic [WIDTH-1:0] SECP_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [WIDTH-1:0] GX =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;

  logic clk = 1'b0;
  logic rst;

  int errors      = 0;
  int checks      = 0;
  int doneCount   = 0;
  int issuedCount = 0;
  logic prevDone  = 1'b0;
  logic [WIDTH-1:0] curP = SECP_P;
  logic [WIDTH-1:0] expQ[$];

  mod_mul_serial_if #(.WIDTH(WIDTH)) bus ();

  mod_mul_serial #(
    .WIDTH(WIDTH),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Reference product: plain double-width multiply followed by modulo
  function automatic logic [WIDTH-1:0] modMul(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    prod = prod % {{WIDTH{1'b0}}, m};
    return prod[WIDTH-1:0];
  endfunction

  // Reference exponentiation, used to obtain x^(p-2) = x^-1 for prime p
  function automatic logic [WIDTH-1:0] modPow(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] e,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] base;
    acc  = 1;
    base = x;
    for (int i = 0; i < WIDTH; i++) begin
      if (e[i]) acc = modMul(acc, base, m);
      base = modMul(base, base, m);
    end
    return acc;
  endfunction

  // Uniform-ish random value below m; m has its top bit set so one
  // subtraction always suffices
  function automatic logic [WIDTH-1:0] randBelow(input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom();
    if (v >= m) v = v - m;
    return v;
  endfunction

  // Random odd modulus above 2^(WIDTH-1)
  function automatic logic [WIDTH-1:0] randModulus();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom();
    v[WIDTH-1] = 1'b1;
    v[0]       = 1'b1;
    return v;
  endfunction

  // Single comparison point: counts every check and reports each failure
  task automatic checkOutput(input string name,
                             input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Called at a negedge with the DUT idle: presents one request across the
  // next rising edge and confirms it was taken. Leaves us at the negedge
  // after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y,
                               input logic [WIDTH-1:0] m,
                               input bit pushExp);
    bus.a     = x;
    bus.b     = y;
    bus.p     = m;
    bus.start = 1'b1;
    curP      = m;
    if (pushExp) begin
      expQ.push_back(modMul(x, y, m));
      issuedCount++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busy after accept", WIDTH'(bus.busy), WIDTH'(1));
    checkOutput("done after accept", WIDTH'(bus.done), WIDTH'(0));
  endtask

  // Waits, with a bound, for done; 'elapsed' is the number of negedges already
  // passed since the accepting edge. done must appear WIDTH edges after it.
  task automatic waitDone(input int elapsed);
    int cycles;
    cycles = elapsed;
    while (!bus.done && cycles < WIDTH + 50) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("latency", WIDTH'(cycles), WIDTH'(WIDTH));
    checkOutput("busy low with done", WIDTH'(bus.busy), WIDTH'(0));
  endtask

  task automatic runOp(input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y,
                       input logic [WIDTH-1:0] m);
    applyStimulus(x, y, m, 1'b1);
    waitDone(0);
  endtask

  // Monitor: on each done pulse pop the oldest expectation and compare; a done
  // with nothing outstanding, or a done lasting two cycles, is an error.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      doneCount++;
      checkOutput("done pulse width", WIDTH'(prevDone), WIDTH'(0));
      if (expQ.size() == 0) begin
        checkOutput("unexpected done", WIDTH'(1), WIDTH'(0));
      end else begin
        checkOutput("result r", bus.r, expQ.pop_front());
      end
    end
    prevDone = bus.done;
  end

  // Accumulator must stay reduced after every iteration of an in-range operation
  always @(negedge clk) begin
    if (!rst && bus.busy) begin
      checkOutput("acc below p", WIDTH'(dut.r_acc < curP), WIDTH'(1));
    end
  end

  // Main sequence
  initial begin
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] pow128;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.p     = SECP_P;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", WIDTH'(bus.busy), WIDTH'(0));
    checkOutput("reset done", WIDTH'(bus.done), WIDTH'(0));
    checkOutput("reset r", bus.r, '0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases over secp256k1
    pow128 = '0;
    pow128[128] = 1'b1;
    runOp(GX, 1, SECP_P);
    runOp(GX, 0, SECP_P);
    runOp(SECP_P - 1, SECP_P - 1, SECP_P);
    runOp(SECP_P - 1, 2, SECP_P);
    runOp(pow128, pow128, SECP_P);

    // Inversion cross-check: x * x^(p-2) must give 1
    for (int k = 0; k < 3; k++) begin
      x = randBelow(SECP_P);
      if (x == '0) x = 1;
      y = modPow(x, SECP_P - 2, SECP_P);
      runOp(x, y, SECP_P);
    end

    // Random back-to-back operations over secp256k1
    for (int k = 0; k < 25; k++) begin
      runOp(randBelow(SECP_P), randBelow(SECP_P), SECP_P);
    end

    // Random operations over other odd moduli
    for (int k = 0; k < 8; k++) begin
      m = randModulus();
      runOp(randBelow(m), randBelow(m), m);
    end

    // A start pulse and operand changes while busy must be ignored
    x = randBelow(SECP_P);
    y = randBelow(SECP_P);
    applyStimulus(x, y, SECP_P, 1'b1);
    repeat (99) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = randBelow(SECP_P);
    bus.b     = randBelow(SECP_P);
    bus.p     = randModulus();
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busy during ignored start", WIDTH'(bus.busy), WIDTH'(1));
    waitDone(100);
    repeat (WIDTH + 10) @(negedge clk);

    // Reset in the middle of an operation aborts it with no done
    applyStimulus(randBelow(SECP_P), randBelow(SECP_P), SECP_P, 1'b0);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", WIDTH'(bus.busy), WIDTH'(0));
    checkOutput("abort done", WIDTH'(bus.done), WIDTH'(0));
    checkOutput("abort r", bus.r, '0);
    rst = 1'b0;
    repeat (WIDTH + 20) @(negedge clk);
    runOp(GX, GX, SECP_P);

    @(negedge clk);
    checkOutput("scoreboard drained", WIDTH'(expQ.size()), WIDTH'(0));
    checkOutput("done count", WIDTH'(doneCount), WIDTH'(issuedCount));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
